// File: rtl/alu_sequencer.sv
// alu_sequencer: 4-state sequencer feeding an external ALU from an 8-entry register file; ports: clk/reset, instr_valid/instr_ready/instr handshake, alu_op/alu_in1/alu_in2 -> alu_out, done/result/result_rd writeback, dbg_addr -> dbg_data read port
module alu_sequencer #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [15:0]           instr,
  output logic [2:0]            alu_op,
  output logic [WORD_WIDTH-1:0] alu_in1,
  output logic [WORD_WIDTH-1:0] alu_in2,
  input  logic [WORD_WIDTH-1:0] alu_out,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] result,
  output logic [2:0]            result_rd,
  input  logic [2:0]            dbg_addr,
  output logic [WORD_WIDTH-1:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;
  state_t state_q, state_d;
  logic [WORD_WIDTH-1:0] rf_q [8];
  logic [2:0] alu_op_q, rd_q, result_rd_q;
  logic [WORD_WIDTH-1:0] alu_in1_q, alu_in2_q, result_q, wb_d;
  logic [7:0] imm_q;
  logic ldi_q, accept;
  logic unused_bits;
  assign unused_bits = ^instr[2:0];
  assign instr_ready = state_q == IDLE && !reset;
  assign accept = instr_ready && instr_valid;
  assign alu_op = alu_op_q;
  assign alu_in1 = alu_in1_q;
  assign alu_in2 = alu_in2_q;
  assign dbg_data = rf_q[dbg_addr];
  always_comb begin
    state_d = accept ? (instr[15] ? WRITE : ISSUE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT ? WRITE :
              state_q == WRITE ? IDLE : state_q;
    wb_d = ldi_q ? {{(WORD_WIDTH-8){1'b0}}, imm_q} : alu_out;
    // done is gated by reset so an aborted WRITE never pulses
    done = state_q == WRITE && !reset;
    // during WRITE the outgoing value is shown live; it is latched on leaving WRITE
    result = done ? wb_d : result_q;
    result_rd = done ? rd_q : result_rd_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rf_q <= '{default: '0};
      alu_op_q <= '0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
      ldi_q <= 1'b0;
      rd_q <= '0;
      imm_q <= '0;
      result_q <= '0;
      result_rd_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ldi_q <= instr[15];
        rd_q <= instr[15] ? instr[14:12] : instr[11:9];
        imm_q <= instr[7:0];
        // operands captured at accept time, so rd==rs sees pre-write values
        if (!instr[15]) begin
          alu_op_q <= instr[14:12];
          alu_in1_q <= rf_q[instr[8:6]];
          alu_in2_q <= rf_q[instr[5:3]];
        end
      end
      if (done) begin
        result_q <= wb_d;
        result_rd_q <= rd_q;
        if (rd_q != 3'd0) rf_q[rd_q] <= wb_d;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;
  logic clk = 0, reset = 1, instr_valid = 0;
  logic [15:0] instr = '0;
  logic instr_ready, done;
  logic [2:0] alu_op, result_rd, dbg_addr = '0;
  logic [15:0] alu_in1, alu_in2, alu_out, result, dbg_data;
  logic [18:0] sb [$];
  logic [15:0] mr [8];
  logic [2:0] lop;
  logic [15:0] l1, l2;
  int checks = 0, errors = 0;

  alu_sequencer #(.WORD_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .done(done), .result(result), .result_rd(result_rd),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, b);
    case (op)
      3'd0: alu_f = a + b;
      3'd1: alu_f = a - b;
      3'd2: alu_f = a * b;
      3'd3: alu_f = {15'd0, $signed(a) < $signed(b)};
      3'd4: alu_f = a & b;
      3'd5: alu_f = a | b;
      3'd6: alu_f = a ^ b;
      default: alu_f = a << b[3:0];
    endcase
  endfunction

  assign alu_out = alu_f(alu_op, alu_in1, alu_in2);

  function automatic logic [15:0] ai(input logic [2:0] op, rd, rs1, rs2);
    ai = {1'b0, op, rd, rs1, rs2, 3'b101};
  endfunction

  function automatic logic [15:0] li(input logic [2:0] rd, input logic [7:0] imm);
    li = {1'b1, rd, 4'h0, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        logic [18:0] e;
        e = sb.pop_front();
        chk("result", result, e[15:0]);
        chk("result_rd", result_rd, e[18:16]);
      end
    end
  end

  task automatic send(input logic [15:0] ins, input bit hold);
    logic ldi;
    logic [2:0] rd, op;
    logic [15:0] a, b, e;
    int n, low;
    ldi = ins[15];
    rd = ldi ? ins[14:12] : ins[11:9];
    op = ins[14:12];
    a = mr[ins[8:6]];
    b = mr[ins[5:3]];
    e = ldi ? {8'h00, ins[7:0]} : alu_f(op, a, b);
    @(negedge clk);
    instr = ins;
    instr_valid = 1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready", instr_ready, 1);
    sb.push_back({rd, e});
    @(posedge clk);
    #1;
    if (!hold) begin
      instr_valid = $urandom_range(0, 1);
      instr = 16'($urandom);
    end
    if (!ldi) begin
      lop = op;
      l1 = a;
      l2 = b;
    end
    if (rd != 0) mr[rd] = e;
    n = 0;
    low = 0;
    do begin
      @(negedge clk);
      n++;
      if (!instr_ready) low++;
      chk("alu_hold", {alu_op, alu_in1, alu_in2}, {lop, l1, l2});
    end while (!done && n < 10);
    instr_valid = 0;
    chk("latency", n, ldi ? 1 : 3);
    chk("busy_cycles", low, n);
    @(posedge clk);
    #1 dbg_addr = rd;
    #1 chk("dbg_rd", dbg_data, mr[rd]);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) mr[i] = '0;
    lop = '0;
    l1 = '0;
    l2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_alu", {alu_op, alu_in1, alu_in2}, 0);
    chk("rst_result", {result_rd, result}, 0);
    reset = 0;
    @(negedge clk);
    chk("ready_after_rst", instr_ready, 1);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1 chk("dbg_rst", dbg_data, 0);
    end
    send(li(1, 8'd5), 0);
    send(li(2, 8'd3), 0);
    send(ai(0, 3, 1, 2), 0);
    send(ai(1, 4, 2, 1), 0);
    send(ai(3, 5, 0, 1), 0);
    send(li(0, 8'hAA), 0);
    send(li(6, 8'hF0), 0);
    send(ai(2, 7, 6, 2), 0);
    send(ai(4, 7, 6, 1), 0);
    send(ai(5, 7, 7, 4), 0);
    send(ai(6, 3, 4, 6), 0);
    send(ai(7, 6, 2, 1), 0);
    send(ai(3, 7, 4, 1), 0);
    send(ai(0, 0, 1, 2), 0);
    send(ai(0, 1, 1, 1), 1);
    chk("r1_doubled", mr[1], 16'd10);
    dbg_addr = 3'd0;
    #1 chk("r0_zero", dbg_data, 0);
    chk("sb_empty", sb.size(), 0);
    @(negedge clk);
    instr = ai(2, 6, 1, 2);
    instr_valid = 1;
    @(posedge clk);
    #1 instr_valid = 0;
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("abort_done", done, 0);
    chk("abort_ready", instr_ready, 0);
    @(negedge clk);
    chk("abort_done2", done, 0);
    reset = 0;
    @(negedge clk);
    chk("abort_ready_after", instr_ready, 1);
    chk("abort_done3", done, 0);
    chk("abort_alu", {alu_op, alu_in1, alu_in2}, 0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1 chk("dbg_abort", dbg_data, 0);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WORD_WIDTH, default 16, datapath width; SHALL be >= 8.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr_valid  input  1  instruction word present on instr.
REQ-005 instr_ready  output  1  sequencer can accept an instruction this cycle.
REQ-006 instr  input  16  instruction word, sampled when instr_valid && instr_ready.
REQ-007 alu_op  output  3  op code to ALU: ADD=0, SUB=1, MUL=2, SLT=3, AND=4, OR=5, XOR=6, SHIFT=7.
REQ-008 alu_in1, alu_in2  output  WORD_WIDTH each  ALU operands.
REQ-009 alu_out  input  WORD_WIDTH  ALU result.
REQ-010 done  output  1  one-cycle pulse on register writeback.
REQ-011 result  output  WORD_WIDTH  value written at done; held until next done.
REQ-012 result_rd  output  3  destination register of the last writeback.
REQ-013 dbg_addr  input  3 / dbg_data  output  WORD_WIDTH  combinational register-file read port.

Function
REQ-014 Internal register file SHALL be 8 x WORD_WIDTH; r0 reads 0, writes to r0 discarded.
REQ-015 instr[15]=1 (LDI): rd=instr[14:12], imm=instr[7:0] zero-extended to WORD_WIDTH.
REQ-016 instr[15]=0 (ALU): op=instr[14:12], rd=instr[11:9], rs1=instr[8:6], rs2=instr[5:3]; instr[2:0] ignored.
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, WRITE; instr_ready=1 only in IDLE.
REQ-018 IDLE + handshake: ALU instr -> ISSUE; LDI -> WRITE; no handshake -> stay IDLE.
REQ-019 ISSUE: alu_op<=op, alu_in1<=reg[rs1], alu_in2<=reg[rs2] (register-file values at accept time) -> WAIT.
REQ-020 WAIT: alu_op/alu_in1/alu_in2 held unchanged (ALU settling cycle) -> WRITE.
REQ-021 WRITE: reg[rd]<=alu_out (ALU) or imm (LDI); done=1; result, result_rd updated -> IDLE.
REQ-022 Latency from accept edge N: ALU instr done at N+3, LDI done at N+1; ALU throughput one instr per 4 cycles.
REQ-023 alu_op/alu_in1/alu_in2 SHALL change only on entry to ISSUE; hold last values otherwise.
REQ-024 rd equal to rs1 or rs2: operands SHALL use pre-write values.
REQ-025 instr_valid while not IDLE: ignored, no accept, instr need not be stable.
REQ-026 Write to r0: done and result SHALL still reflect the computed value; r0 remains 0.
REQ-027 result is alu_out verbatim (ALU truncates to WORD_WIDTH); sequencer performs no arithmetic.
REQ-028 dbg_data=reg[dbg_addr] combinationally, reflecting writes from the following cycle.

Reset
REQ-029 reset SHALL force IDLE; all registers, alu_op, alu_in1, alu_in2, result, result_rd =0; done=0.
REQ-030 instr_ready SHALL be 0 while reset is high and 1 in the first cycle after release.
REQ-031 reset mid-instruction (ISSUE/WAIT/WRITE) SHALL abort: no done pulse.
REQ-032 Reset takes priority over any handshake in the same cycle.

Verification (WORD_WIDTH=16)
REQ-033 reset high 2 cycles -> instr_ready=0, done=0, alu_* =0; after release instr_ready=1, dbg_data=0 for r0..r7.
REQ-034 LDI r1,5; LDI r2,3; ADD r3,r1,r2 -> alu_op=0, alu_in1=5, alu_in2=3 from ISSUE; done at N+3, result=8, result_rd=3, dbg r3=8.
REQ-035 then SUB r4,r2,r1 -> result=0xFFFE; SLT r5,r0,r1 -> result=1.
REQ-036 LDI r0,0xAA -> done=1, result=0x00AA, result_rd=0; dbg r0=0.
REQ-037 r1=5, ADD r1,r1,r1 with instr_valid held high throughout -> single accept, alu_in1=alu_in2=5, r1=10, instr_ready low 3 cycles.
REQ-038 MUL r6,r1,r2 with reset asserted in WAIT -> no done, all registers 0, instr_ready=1 after release.
